register_file_mp: RTL and testbench
===================================

# register_file_mp

Multi-ported, parametrised register file with scoreboard bits, one generation on from the single-write-port file. It provides RD_PORTS combinational read ports and WR_PORTS synchronous write ports, plus an optionally hard-wired zero register. It also keeps per-register pending (busy) bits so the issue stage can stall on in-flight results. It sits between decode/issue and the execute/writeback ports of the datapath.

## Interface
- DATA_WIDTH, 32, word width
- REG_DEPTH, 32, number of registers
- RD_PORTS, 2, parallel read ports
- WR_PORTS, 2, parallel write ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations
- ADDR_WIDTH, log2(REG_DEPTH), address width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  WR_PORTS  per-port write enable
- wr_addr  in  ADDR_WIDTH*WR_PORTS  packed write addresses; port k at bits [ADDR_WIDTH*k +: ADDR_WIDTH]
- wr_data  in  DATA_WIDTH*WR_PORTS  packed write data
- rd_addr  in  ADDR_WIDTH*RD_PORTS  packed read addresses
- rd_data  out  DATA_WIDTH*RD_PORTS  packed read data
- rsv_en  in  1  reserve (mark pending) register rsv_addr
- rsv_addr  in  ADDR_WIDTH  register to reserve
- flush  in  1  synchronously clear all pending bits
- rd_busy  out  RD_PORTS  pending bit of each read address

## Operation
- Storage: REG_DEPTH x DATA_WIDTH array, plus REG_DEPTH pending bits.
- Write: at posedge clk, for each k with wr_en[k], reg[wr_addr[k]] <= wr_data[k].
- Same-address collision between write ports: the highest-index port wins.
- Writes to addresses >= REG_DEPTH are ignored.
- Pending bits, evaluated each posedge in priority order:
  - flush=1: all bits cleared; rsv_en is ignored in that cycle.
  - Otherwise, a write to address a clears pending[a].
  - Otherwise, rsv_en sets pending[rsv_addr]; a reservation overrides a same-cycle write clear of the same register, because the new producer wins.
- Read: rd_data[i] = reg[rd_addr[i]], combinational. rd_busy[i] = pending[rd_addr[i]].
- ZERO_REG=1:
  - Address 0 reads 0 and rd_busy is 0.
  - Writes and reservations to register 0 are dropped.
- Out-of-range read address returns 0 with busy 0.

## Timing
- rst asserted asynchronously clears every register and pending bit immediately.
  - rd_data reads all zeros and rd_busy is all zeros while rst is high.
  - Writes, reservations and flush presented during reset are discarded.
- Reset released mid-stream: the first capturing edge is the first posedge with rst low.
- Write-to-read latency without bypass: 1 cycle (data visible after the capturing edge).
- Reserve-to-busy latency: 1 cycle. Write-clears-busy latency: 1 cycle without bypass.
- No handshakes; every port is accepted every cycle.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If any wr_en[k] targets rd_addr[i], rd_data[i] = wr_data of the highest such k.
  - rd_busy[i] = 0 in that cycle unless rsv_en targets the same address.
  - Forwarding is combinational from the write ports to the read ports.
  - Zero-register rules still apply.
- Undefined: no forwarding; reads reflect only stored state (1-cycle write latency as above).

## Structure
- Shared package regfile_pkg:
  - log2 function
  - default width/depth constants
  - pack/unpack helpers for vectorised port arrays
- One natural sub-module: the existing parametrised mux (BIT_WIDTH, DEPTH, SEL_WIDTH), one instance per read port fed by the packed register vector.
- Bypass, zero-masking and busy selection are local logic in register_file_mp.

## Test plan
- Reset: after async rst pulse mid-cycle, read all 32 addresses on both ports -> rd_data=0, rd_busy=0; a write held during rst has no effect.
- Dual write: port0 writes r5=0xAAAA_0001, port1 writes r9=0x5555_0002; next cycle read r5/r9 -> 0xAAAA_0001/0x5555_0002. Then both ports write r7 (0x1, 0x2) -> r7 reads 0x2.
- Zero register: write r0=0xFFFF_FFFF and rsv r0 -> reads 0, busy 0. With ZERO_REG=0 the same stimulus -> reads 0xFFFF_FFFF, busy 1.
- Scoreboard:
  - rsv r3 -> rd_busy=1 next cycle.
  - Write r3=0x42 -> busy 0, data 0x42.
  - Same-cycle write r3 plus rsv r3 -> busy stays 1.
  - flush with rsv r4 -> all busy 0.
- Bypass (REGFILE_BYPASS_EN): write r12=0xDEAD_BEEF while reading r12 -> rd_data=0xDEAD_BEEF in the same cycle. Without the macro -> old value that cycle, new value next cycle.
- Parametrisation: RD_PORTS=4, WR_PORTS=3, REG_DEPTH=64, DATA_WIDTH=64; random writes/reads checked against a reference model for 10k cycles -> zero mismatches.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-ported register file.
//   - clog2():  address width for a given depth (never less than 1)
//   - DEF_*:    default word width / depth
//   - lane_lo(): low bit of lane k inside a packed vectorised port bus,
//                used to pack/unpack wr_addr, wr_data, rd_addr, rd_data
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_REG_DEPTH  = 32;
   localparam int DEF_RD_PORTS   = 2;
   localparam int DEF_WR_PORTS   = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/register_file_mp_mux.sv
// regfile_mux: combinational N:1 word selector over a flat packed vector.
//   data_in  : DEPTH words of BIT_WIDTH, word d at [d*BIT_WIDTH +: BIT_WIDTH]
//   sel      : word index; an index with no matching word yields 0
//   data_out : selected word
module regfile_mux #(
   parameter int BIT_WIDTH = 32,
   parameter int DEPTH     = 32,
   parameter int SEL_WIDTH = 5
) (
   input  logic [DEPTH*BIT_WIDTH-1:0] data_in,
   input  logic [SEL_WIDTH-1:0]       sel,
   output logic [BIT_WIDTH-1:0]       data_out
);

   always_comb begin
      data_out = '0;
      for (int d = 0; d < DEPTH; d++) begin
         if (sel == SEL_WIDTH'(d)) data_out = data_in[d*BIT_WIDTH +: BIT_WIDTH];
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: RD_PORTS combinational read / WR_PORTS synchronous write
// register file with per-register pending (scoreboard) bits.
//   clk, rst         : rising-edge clock, async active-high reset
//   wr_en/addr/data  : packed write ports, higher port index wins collisions
//   rd_addr/rd_data  : packed combinational read ports
//   rd_busy          : pending bit of each read address
//   rsv_en/rsv_addr  : mark a register pending (new producer in flight)
//   flush            : clear every pending bit (reservation ignored that cycle)
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_DEPTH  = DEF_REG_DEPTH,
   parameter int RD_PORTS   = DEF_RD_PORTS,
   parameter int WR_PORTS   = DEF_WR_PORTS,
   parameter int ZERO_REG   = 1,
   parameter int ADDR_WIDTH = clog2(REG_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WR_PORTS-1:0]            wr_en,
   input  logic [ADDR_WIDTH*WR_PORTS-1:0] wr_addr,
   input  logic [DATA_WIDTH*WR_PORTS-1:0] wr_data,
   input  logic [ADDR_WIDTH*RD_PORTS-1:0] rd_addr,
   output logic [DATA_WIDTH*RD_PORTS-1:0] rd_data,
   input  logic                           rsv_en,
   input  logic [ADDR_WIDTH-1:0]          rsv_addr,
   input  logic                           flush,
   output logic [RD_PORTS-1:0]            rd_busy
);

   logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [REG_DEPTH-1:0]                 pend_q, pend_d;

   logic [WR_PORTS-1:0][ADDR_WIDTH-1:0]  wa_v;
   logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  wd_v;

   // An address names real, writable storage: in range and not the
   // hard-wired zero register.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < REG_DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   for (genvar k = 0; k < WR_PORTS; k++) begin : g_wr_unpack
      assign wa_v[k] = wr_addr[lane_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      assign wd_v[k] = wr_data[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
   end

   // Ascending port order makes the highest-index port win collisions.
   // The reservation is applied after the write clears so a new producer
   // keeps the register pending; flush overrides everything.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      for (int k = 0; k < WR_PORTS; k++) begin
         if (wr_en[k] && addr_ok(wa_v[k])) begin
            regs_d[wa_v[k]] = wd_v[k];
            pend_d[wa_v[k]] = 1'b0;
         end
      end
      if (rsv_en && addr_ok(rsv_addr)) pend_d[rsv_addr] = 1'b1;
      if (flush) pend_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] mux_out;
      logic [DATA_WIDTH-1:0] rdata;
      logic                  busy;

      assign ra = rd_addr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];

      regfile_mux #(
         .BIT_WIDTH (DATA_WIDTH),
         .DEPTH     (REG_DEPTH),
         .SEL_WIDTH (ADDR_WIDTH)
      ) u_mux (
         .data_in  (regs_q),
         .sel      (ra),
         .data_out (mux_out)
      );

      always_comb begin
         rdata = '0;
         busy  = 1'b0;
         if (addr_ok(ra)) begin
            rdata = mux_out;
            busy  = pend_q[ra];
         end
`ifdef REGFILE_BYPASS_EN
         // Forwarding is suppressed in reset so reads stay zero while the
         // write ports may still be driven.
         if (addr_ok(ra) && !rst) begin
            for (int k = 0; k < WR_PORTS; k++) begin
               if (wr_en[k] && (wa_v[k] == ra)) begin
                  rdata = wd_v[k];
                  busy  = rsv_en && (rsv_addr == ra);
               end
            end
         end
`endif
      end

      assign rd_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rdata;
      assign rd_busy[i] = busy;
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks on the default configuration and a
// ZERO_REG=0 copy, then randomized traffic on a 4R/3W 64x64 configuration
// compared with an array-based reference model.
module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk, rst;
   int   n_chk, n_err;

   // default configuration
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        flush;
   logic [1:0]  rd_busy;

   // ZERO_REG=0 copy
   logic [1:0]  z_wr_en;
   logic [9:0]  z_wr_addr;
   logic [63:0] z_wr_data;
   logic [9:0]  z_rd_addr;
   logic [63:0] z_rd_data;
   logic        z_rsv_en;
   logic [4:0]  z_rsv_addr;
   logic        z_flush;
   logic [1:0]  z_rd_busy;

   // 4R/3W, 64 x 64
   logic [2:0]   p_wr_en;
   logic [17:0]  p_wr_addr;
   logic [191:0] p_wr_data;
   logic [23:0]  p_rd_addr;
   logic [255:0] p_rd_data;
   logic         p_rsv_en;
   logic [5:0]   p_rsv_addr;
   logic         p_flush;
   logic [3:0]   p_rd_busy;

   register_file_mp u_dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .flush(flush), .rd_busy(rd_busy)
   );

   register_file_mp #(.ZERO_REG(0)) u_dutz (
      .clk(clk), .rst(rst), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
      .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr),
      .flush(z_flush), .rd_busy(z_rd_busy)
   );

   register_file_mp #(
      .DATA_WIDTH(64), .REG_DEPTH(64), .RD_PORTS(4), .WR_PORTS(3), .ZERO_REG(1)
   ) u_dutp (
      .clk(clk), .rst(rst), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
      .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr),
      .flush(p_flush), .rd_busy(p_rd_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] d0(input int i);
      return rd_data[i*32 +: 32];
   endfunction

   function automatic logic [5:0] pick();
      if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 7));
      return 6'($urandom_range(0, 63));
   endfunction

   // reference model state for the 4R/3W instance
   logic [63:0] m_mem  [64];
   bit          m_pend [64];

   initial begin
      logic [5:0]  a, wa;
      logic [63:0] ed;
      bit          eb, hit;

      n_chk = 0; n_err = 0;
      rst = 1'b1;
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; rsv_en = 0; rsv_addr = '0; flush = 0;
      z_wr_en = '0; z_wr_addr = '0; z_wr_data = '0; z_rd_addr = '0; z_rsv_en = 0; z_rsv_addr = '0; z_flush = 0;
      p_wr_en = '0; p_wr_addr = '0; p_wr_data = '0; p_rd_addr = '0; p_rsv_en = 0; p_rsv_addr = '0; p_flush = 0;
      for (int r = 0; r < 64; r++) begin m_mem[r] = '0; m_pend[r] = 0; end

      // reset state
      rd_addr = {5'd9, 5'd5};
      #1;
      chk("init_data0", 64'(d0(0)), 64'h0);
      chk("init_busy", 64'(rd_busy), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // dual write, different registers
      wr_en = 2'b11; wr_addr = {5'd9, 5'd5}; wr_data = {32'h5555_0002, 32'hAAAA_0001};
      #1;
      chk("dual_same_cyc", 64'(d0(0)), BYP ? 64'hAAAA_0001 : 64'h0);
      cyc();
      wr_en = '0;
      #1;
      chk("dual_r5", 64'(d0(0)), 64'hAAAA_0001);
      chk("dual_r9", 64'(d0(1)), 64'h5555_0002);

      // both ports write r7: port 1 wins
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1}; rd_addr = {5'd7, 5'd7};
      #1;
      chk("coll_same_cyc", 64'(d0(1)), BYP ? 64'h2 : 64'h0);
      cyc();
      wr_en = '0;
      #1;
      chk("coll_r7", 64'(d0(0)), 64'h2);

      // write r12 while reading it
      wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'hDEAD_BEEF}; rd_addr = {5'd9, 5'd12};
      #1;
      chk("byp_data", 64'(d0(0)), BYP ? 64'hDEAD_BEEF : 64'h0);
      chk("byp_busy", 64'(rd_busy[0]), 64'h0);
      cyc();
      wr_en = '0;
      #1;
      chk("byp_next", 64'(d0(0)), 64'hDEAD_BEEF);

      // scoreboard: reserve r3
      rsv_en = 1; rsv_addr = 5'd3; rd_addr = {5'd4, 5'd3};
      #1;
      chk("rsv_same_cyc", 64'(rd_busy[0]), 64'h0);
      cyc();
      rsv_en = 0;
      #1;
      chk("rsv_busy", 64'(rd_busy[0]), 64'h1);

      // write r3 clears pending
      wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h42, 32'h0};
      #1;
      chk("wclr_same_busy", 64'(rd_busy[0]), BYP ? 64'h0 : 64'h1);
      chk("wclr_same_data", 64'(d0(0)), BYP ? 64'h42 : 64'h0);
      cyc();
      wr_en = '0;
      #1;
      chk("wclr_busy", 64'(rd_busy[0]), 64'h0);
      chk("wclr_data", 64'(d0(0)), 64'h42);

      // write and reserve r3 in the same cycle: reservation wins
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55}; rsv_en = 1; rsv_addr = 5'd3;
      #1;
      chk("wrsv_same_busy", 64'(rd_busy[0]), BYP ? 64'h1 : 64'h0);
      cyc();
      wr_en = '0; rsv_en = 0;
      #1;
      chk("wrsv_busy", 64'(rd_busy[0]), 64'h1);
      chk("wrsv_data", 64'(d0(0)), 64'h55);

      // reserve r4 too, then flush while reserving r4
      rsv_en = 1; rsv_addr = 5'd4;
      cyc();
      #1;
      chk("rsv4_busy", 64'(rd_busy[1]), 64'h1);
      flush = 1;
      cyc();
      flush = 0; rsv_en = 0;
      #1;
      chk("flush_busy", 64'(rd_busy), 64'h0);

      // zero register on both ZERO_REG settings
      wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFF_FFFF}; rsv_en = 1; rsv_addr = '0; rd_addr = '0;
      z_wr_en = 2'b01; z_wr_addr = '0; z_wr_data = {32'h0, 32'hFFFF_FFFF}; z_rsv_en = 1; z_rsv_addr = '0; z_rd_addr = '0;
      #1;
      chk("zero_same_data", 64'(d0(0)), 64'h0);
      chk("zero_same_busy", 64'(rd_busy), 64'h0);
      chk("nz_same_data", 64'(z_rd_data[31:0]), BYP ? 64'hFFFF_FFFF : 64'h0);
      chk("nz_same_busy", 64'(z_rd_busy[0]), BYP ? 64'h1 : 64'h0);
      cyc();
      wr_en = '0; rsv_en = 0; z_wr_en = '0; z_rsv_en = 0;
      #1;
      chk("zero_data", 64'(d0(1)), 64'h0);
      chk("zero_busy", 64'(rd_busy), 64'h0);
      chk("nz_data", 64'(z_rd_data[63:32]), 64'hFFFF_FFFF);
      chk("nz_busy", 64'(z_rd_busy), 64'h3);

      // pending r8, then async reset mid-cycle with a write held on r5
      rsv_en = 1; rsv_addr = 5'd8;
      cyc();
      rsv_en = 0; rd_addr = {5'd8, 5'd5};
      #1;
      chk("pre_rst_busy", 64'(rd_busy[1]), 64'h1);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234_5678};
      rsv_en = 1; rsv_addr = 5'd5;
      #2 rst = 1'b1;
      for (int r = 0; r < 32; r++) begin
         rd_addr = {5'(31 - r), 5'(r)};
         #1;
         chk("rst_data", rd_data, 64'h0);
         chk("rst_busy", 64'(rd_busy), 64'h0);
      end
      @(negedge clk);
      rst = 1'b0; wr_en = '0; rsv_en = 0; rd_addr = {5'd8, 5'd5};
      cyc();
      #1;
      chk("post_rst_r5", 64'(d0(0)), 64'h0);
      chk("post_rst_busy", 64'(rd_busy), 64'h0);
      rd_addr = {5'd9, 5'd3};
      #1;
      chk("post_rst_r9r3", rd_data, 64'h0);

      // randomized traffic on the wide configuration
      for (int c = 0; c < 10000; c++) begin
         p_flush    = ($urandom_range(0, 15) == 0);
         p_rsv_en   = 1'($urandom_range(0, 1));
         p_rsv_addr = pick();
         for (int k = 0; k < 3; k++) begin
            p_wr_en[k]            = 1'($urandom_range(0, 1));
            p_wr_addr[k*6 +: 6]   = pick();
            p_wr_data[k*64 +: 64] = {$urandom, $urandom};
         end
         for (int i = 0; i < 4; i++) p_rd_addr[i*6 +: 6] = pick();
         #1;
         for (int i = 0; i < 4; i++) begin
            a  = p_rd_addr[i*6 +: 6];
            ed = (a == 0) ? 64'h0 : m_mem[a];
            eb = (a == 0) ? 1'b0 : m_pend[a];
            hit = 0;
            if (BYP && a != 0) begin
               for (int k = 0; k < 3; k++) begin
                  if (p_wr_en[k] && p_wr_addr[k*6 +: 6] == a) begin
                     ed  = p_wr_data[k*64 +: 64];
                     hit = 1;
                  end
               end
               if (hit) eb = p_rsv_en && (p_rsv_addr == a);
            end
            chk("rnd_data", p_rd_data[i*64 +: 64], ed);
            chk("rnd_busy", 64'(p_rd_busy[i]), 64'(eb));
         end
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            wa = p_wr_addr[k*6 +: 6];
            if (p_wr_en[k] && wa != 0) m_mem[wa] = p_wr_data[k*64 +: 64];
         end
         if (p_flush) begin
            for (int r = 0; r < 64; r++) m_pend[r] = 0;
         end else begin
            for (int k = 0; k < 3; k++) begin
               wa = p_wr_addr[k*6 +: 6];
               if (p_wr_en[k] && wa != 0) m_pend[wa] = 0;
            end
            if (p_rsv_en && p_rsv_addr != 0) m_pend[p_rsv_addr] = 1;
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
